// File: rtl/fdtd_wt_pkg.sv
// Shared types and widths for the FDTD write-stream stages.
package fdtd_wt_pkg;

  typedef enum logic [1:0] {
    WTS_IDLE = 2'd0,
    WTS_RUN  = 2'd1,
    WTS_DONE = 2'd2
  } wt_stream_state_e;

  // Byte address width of the AXI side and the derived word-address width.
  localparam int unsigned WT_BYTE_ADDR_W = 32;
  localparam int unsigned WT_WORD_ADDR_W = WT_BYTE_ADDR_W - 2;

endpackage

// File: rtl/fdtd_sync_fifo.sv
// Synchronous FIFO, pointer based with an extra wrap bit for full/empty.
module fdtd_sync_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]           wr_ptr_q, wr_ptr_d;
  logic [AW:0]           rd_ptr_q, rd_ptr_d;
  logic                  do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointer advance; full is judged before any same-cycle pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage; contents need no reset since the pointers gate visibility.
  always_ff @(posedge ACLK) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/fdtd_wt_stream.sv
// Feeds the single-word writer: buffers result words, stamps each with
// base + i*stride and holds it on req/gnt until granted.
module fdtd_wt_stream
  import fdtd_wt_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = WT_BYTE_ADDR_W,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic                  cfg_start_i,
  input  logic [ADDR_WIDTH-3:0] cfg_base_word_addr_i,
  input  logic [ADDR_WIDTH-3:0] cfg_stride_i,
  input  logic [CNT_WIDTH-1:0]  cfg_len_i,
  output logic                  busy_o,
  output logic                  done_o,
  input  logic                  s_valid_i,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  output logic                  s_ready_o,
  output logic                  wt_req_o,
  output logic [ADDR_WIDTH-3:0] wt_word_addr_o,
  output logic [DATA_WIDTH-1:0] wt_data_o,
  input  logic                  wt_gnt_i
);

  wt_stream_state_e      state_q, state_d;
  logic                  busy_q, busy_d, done_q, done_d;
  logic [ADDR_WIDTH-3:0] stride_q, stride_d, addr_acc_q, addr_acc_d;
  logic [CNT_WIDTH-1:0]  len_q, len_d, in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
  logic                  req_q, req_d;
  logic [ADDR_WIDTH-3:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  logic                  fifo_full, fifo_empty, push, gnt_fire, load;
  logic [DATA_WIDTH-1:0] fifo_data;

  assign s_ready_o = (state_q == WTS_RUN) && !fifo_full && (in_cnt_q < len_q);
  assign push      = s_valid_i && s_ready_o;
  assign gnt_fire  = req_q && wt_gnt_i;
  assign load      = (!req_q || gnt_fire) && !fifo_empty;

  fdtd_sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .push_i  (push),
    .data_i  (s_data_i),
    .pop_i   (load),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Job sequencing, counters and the output holding register.
  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    stride_d   = stride_q;
    len_d      = len_q;
    addr_acc_d = addr_acc_q;
    in_cnt_d   = in_cnt_q;
    out_cnt_d  = out_cnt_q;
    req_d      = req_q;
    addr_d     = addr_q;
    data_d     = data_q;
    case (state_q)
      WTS_IDLE: begin
        if (cfg_start_i) begin
          addr_acc_d = cfg_base_word_addr_i;
          stride_d   = cfg_stride_i;
          len_d      = cfg_len_i;
          in_cnt_d   = '0;
          out_cnt_d  = '0;
          if (cfg_len_i == '0) begin
            state_d = WTS_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = WTS_RUN;
            busy_d  = 1'b1;
          end
        end
      end
      WTS_RUN: begin
        if (push)     in_cnt_d  = in_cnt_q + CNT_WIDTH'(1);
        if (gnt_fire) out_cnt_d = out_cnt_q + CNT_WIDTH'(1);
        if (gnt_fire && (out_cnt_q + CNT_WIDTH'(1) == len_q)) begin
          state_d = WTS_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      WTS_DONE: state_d = WTS_IDLE;
      default:  state_d = WTS_IDLE;
    endcase
    // A grant frees the register; a waiting FIFO word refills it at the same edge.
    if (load) begin
      req_d      = 1'b1;
      addr_d     = addr_acc_q;
      data_d     = fifo_data;
      addr_acc_d = addr_acc_q + stride_q;
    end else if (gnt_fire) begin
      req_d = 1'b0;
    end
  end

  // State and datapath registers; reset aborts any job and drops req at once.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q    <= WTS_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      stride_q   <= '0;
      len_q      <= '0;
      addr_acc_q <= '0;
      in_cnt_q   <= '0;
      out_cnt_q  <= '0;
      req_q      <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      stride_q   <= stride_d;
      len_q      <= len_d;
      addr_acc_q <= addr_acc_d;
      in_cnt_q   <= in_cnt_d;
      out_cnt_q  <= out_cnt_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
    end
  end

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign wt_req_o       = req_q;
  assign wt_word_addr_o = addr_q;
  assign wt_data_o      = data_q;

endmodule

// File: tb/tb_fdtd_wt_stream.sv
// Directed bench for fdtd_wt_stream.
module tb_fdtd_wt_stream;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        cfg_start_i;
  logic [29:0] cfg_base_word_addr_i, cfg_stride_i;
  logic [15:0] cfg_len_i;
  logic        busy_o, done_o, s_valid_i, s_ready_o;
  logic [31:0] s_data_i;
  logic        wt_req_o, wt_gnt_i;
  logic [29:0] wt_word_addr_o;
  logic [31:0] wt_data_o;

  int total = 0;
  int bad   = 0;

  fdtd_wt_stream #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .FIFO_DEPTH(4), .CNT_WIDTH(16)) dut (
    .ACLK                 (ACLK),
    .ARESETn              (ARESETn),
    .cfg_start_i          (cfg_start_i),
    .cfg_base_word_addr_i (cfg_base_word_addr_i),
    .cfg_stride_i         (cfg_stride_i),
    .cfg_len_i            (cfg_len_i),
    .busy_o               (busy_o),
    .done_o               (done_o),
    .s_valid_i            (s_valid_i),
    .s_data_i             (s_data_i),
    .s_ready_o            (s_ready_o),
    .wt_req_o             (wt_req_o),
    .wt_word_addr_o       (wt_word_addr_o),
    .wt_data_o            (wt_data_o),
    .wt_gnt_i             (wt_gnt_i)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  // Runs one job: start pulse, feed len words, grant each req after gdly
  // cycles (no grants during the first hold cycles), check every retired word.
  task automatic run_job(input logic [29:0] base, input logic [29:0] stride,
                         input logic [15:0] len, input logic [31:0] dbase,
                         input int gdly, input int hold, input bit b2b, input bit midstart);
    int in_idx = 0;
    int out_idx = 0;
    int age = 0;
    bit acc, gf, prev_req;
    logic [29:0] pa, ea;
    logic [31:0] pd;
    cfg_base_word_addr_i = base;
    cfg_stride_i = stride;
    cfg_len_i = len;
    cfg_start_i = 1'b1;
    step();
    cfg_start_i = 1'b0;
    check("busy_after_start", busy_o, 1);
    for (int cyc = 0; cyc < 200 && out_idx < int'(len); cyc++) begin
      s_valid_i = (in_idx < int'(len));
      s_data_i  = dbase + 32'(in_idx);
      wt_gnt_i  = (cyc >= hold) && wt_req_o && (age >= gdly);
      cfg_start_i = midstart && (cyc == 3);
      if (cfg_start_i) begin
        cfg_base_word_addr_i = 30'h3AB;
        cfg_len_i = 16'd1;
      end
      acc = s_valid_i && s_ready_o;
      gf = wt_req_o && wt_gnt_i;
      pa = wt_word_addr_o;
      pd = wt_data_o;
      prev_req = wt_req_o;
      step();
      cfg_start_i = 1'b0;
      if (acc) in_idx++;
      if (gf) age = 0;
      else if (prev_req) age++;
      if (gf) begin
        ea = base + stride * 30'(out_idx);
        check("word_addr", 64'(pa), 64'(ea));
        check("word_data", 64'(pd), 64'(dbase + 32'(out_idx)));
        out_idx++;
        if (out_idx == int'(len)) begin
          check("done_pulse", done_o, 1);
          check("busy_at_done", busy_o, 0);
        end else begin
          check("done_early", done_o, 0);
          if (b2b) check("b2b_req_high", wt_req_o, 1);
        end
      end else if (prev_req) begin
        check("req_held", wt_req_o, 1);
        check("addr_stable", 64'(wt_word_addr_o), 64'(pa));
        check("data_stable", 64'(wt_data_o), 64'(pd));
      end
      if (hold > 0 && cyc == hold - 1) begin
        check("hold_accepted", in_idx, (int'(len) < 5) ? int'(len) : 5);
        check("hold_ready_low", s_ready_o, 0);
      end
      if (in_idx == int'(len) && out_idx < int'(len)) check("no_overaccept", s_ready_o, 0);
    end
    check("job_words_retired", out_idx, int'(len));
    s_valid_i = 1'b0;
    wt_gnt_i = 1'b0;
    step();
    check("done_single", done_o, 0);
    check("req_idle", wt_req_o, 0);
  endtask

  initial begin
    ARESETn = 1'b0;
    cfg_start_i = 1'b0;
    cfg_base_word_addr_i = '0;
    cfg_stride_i = '0;
    cfg_len_i = '0;
    s_valid_i = 1'b0;
    s_data_i = '0;
    wt_gnt_i = 1'b0;
    step();
    step();
    check("rst_req", wt_req_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_ready", s_ready_o, 0);
    check("rst_addr", 64'(wt_word_addr_o), 0);
    check("rst_data", 64'(wt_data_o), 0);
    ARESETn = 1'b1;
    step();

    // Basic job, grant three cycles into each request.
    run_job(30'h100, 30'd1, 16'd4, 32'hA000_0000, 3, 0, 1'b0, 1'b0);

    // Word address wraps silently.
    run_job(30'h3FFF_FFFE, 30'd1, 16'd3, 32'hB000_0000, 1, 0, 1'b0, 1'b0);

    // Zero-length job goes straight to done.
    cfg_base_word_addr_i = 30'h55;
    cfg_len_i = 16'd0;
    cfg_start_i = 1'b1;
    s_valid_i = 1'b1;
    step();
    cfg_start_i = 1'b0;
    check("len0_done", done_o, 1);
    check("len0_busy", busy_o, 0);
    check("len0_ready", s_ready_o, 0);
    check("len0_req", wt_req_o, 0);
    step();
    check("len0_done_once", done_o, 0);
    check("len0_req_after", wt_req_o, 0);
    check("len0_ready_after", s_ready_o, 0);
    s_valid_i = 1'b0;

    // Backpressure: five words buffered while grants are held off.
    run_job(30'h040, 30'd4, 16'd8, 32'hC000_0000, 2, 10, 1'b0, 1'b0);

    // Back-to-back grants from a full buffer, with a stray start mid-job.
    run_job(30'h500, 30'd2, 16'd6, 32'hD000_0000, 0, 8, 1'b1, 1'b1);

    // Reset in the middle of a job with a word pending.
    cfg_base_word_addr_i = 30'h200;
    cfg_stride_i = 30'd1;
    cfg_len_i = 16'd4;
    cfg_start_i = 1'b1;
    step();
    cfg_start_i = 1'b0;
    s_valid_i = 1'b1;
    s_data_i = 32'hF000_0000;
    for (int i = 0; i < 4; i++) step();
    check("pre_rst_req", wt_req_o, 1);
    ARESETn = 1'b0;
    #1;
    check("async_rst_req", wt_req_o, 0);
    check("async_rst_busy", busy_o, 0);
    check("async_rst_ready", s_ready_o, 0);
    s_valid_i = 1'b0;
    step();
    ARESETn = 1'b1;
    step();
    run_job(30'h300, 30'd3, 16'd2, 32'hE000_0000, 0, 0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
